// File: rtl/nco_clock_gen.sv
// -----------------------------------------------------------------------------
// nco_clock_gen
//
// Purpose:
//   All-digital programmable clock generator. Each of NUM_CH channels owns an
//   ACC_W-bit phase accumulator that advances by its increment every refclk
//   edge. The accumulator MSB is exported as a derived clock (outclk) and the
//   carry out of the add is exported as a one-cycle clock-enable (outtick).
//   Output frequency = inc * f_refclk / 2^ACC_W.
//
//   Increments and initial phase are reprogrammed one channel at a time over a
//   valid/ready config port. A small SETTLE/IDLE/APPLY state machine drops
//   `locked` for LOCK_CYCLES edges after each reconfiguration and only offers
//   cfg_ready while idle.
//
// Ports:
//   refclk     in   1       sole clock, rising edge
//   rst        in   1       asynchronous active-high reset
//   cfg_valid  in   1       config request valid (hold until accepted)
//   cfg_ready  out  1       config port accepts a request this cycle
//   cfg_ch     in   CH_W    target channel index
//   cfg_inc    in   ACC_W   new phase increment
//   cfg_phase  in   ACC_W   accumulator load value (initial phase)
//   cfg_err    out  1       one-cycle pulse: accepted request had cfg_ch >= NUM_CH
//   outclk     out  NUM_CH  registered accumulator MSB per channel
//   outtick    out  NUM_CH  one-cycle pulse per channel on accumulator wrap
//   locked     out  1       all channels running with settled configuration
// -----------------------------------------------------------------------------
module nco_clock_gen #(
    parameter int                       NUM_CH      = 3,
    parameter int                       ACC_W       = 32,
    parameter int                       LOCK_CYCLES = 1024,
    parameter logic [NUM_CH*ACC_W-1:0]  DEF_INC     = {(NUM_CH*ACC_W){1'b0}},
    parameter int                       CH_W        = 3
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [ACC_W-1:0]    cfg_inc,
    input  logic [ACC_W-1:0]    cfg_phase,
    output logic                cfg_err,
    output logic [NUM_CH-1:0]   outclk,
    output logic [NUM_CH-1:0]   outtick,
    output logic                locked
);

    // Settle counter only ever needs to reach LOCK_CYCLES-1.
    localparam int               CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_IDLE   = 2'd1,
        ST_APPLY  = 2'd2
    } state_t;

    // True when a channel index addresses an existing channel.
    function automatic logic ch_in_range(input logic [CH_W-1:0] ch);
        ch_in_range = (32'(ch) < 32'(NUM_CH));
    endfunction

    // ---------------------------------------------------------------------
    // Control state
    // ---------------------------------------------------------------------
    state_t             state_q,      state_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic               locked_q,     locked_d;
    logic               cfg_ready_q,  cfg_ready_d;
    logic               cfg_err_q,    cfg_err_d;

    // Request captured at the handshake, consumed in APPLY.
    logic [CH_W-1:0]    req_ch_q,     req_ch_d;
    logic [ACC_W-1:0]   req_inc_q,    req_inc_d;
    logic [ACC_W-1:0]   req_phase_q,  req_phase_d;

    // ---------------------------------------------------------------------
    // Per-channel datapath
    // ---------------------------------------------------------------------
    logic [ACC_W-1:0]   acc_q   [NUM_CH];
    logic [ACC_W-1:0]   acc_d   [NUM_CH];
    logic [ACC_W-1:0]   inc_q   [NUM_CH];
    logic [ACC_W-1:0]   inc_d   [NUM_CH];
    logic [ACC_W:0]     sum_s   [NUM_CH];
    logic [NUM_CH-1:0]  outclk_q,  outclk_d;
    logic [NUM_CH-1:0]  outtick_q, outtick_d;

    logic               handshake_s;
    logic               apply_s;

    // Handshake qualifies on the registered ready, so cfg_* never reaches an
    // output through combinational logic.
    assign handshake_s = cfg_valid & cfg_ready_q;
    assign apply_s     = (state_q == ST_APPLY);

    // Next-state logic for the lock/settle FSM and the request latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        locked_d    = locked_q;
        cfg_ready_d = cfg_ready_q;
        cfg_err_d   = 1'b0;
        req_ch_d    = req_ch_q;
        req_inc_d   = req_inc_q;
        req_phase_d = req_phase_q;

        case (state_q)
            ST_SETTLE: begin
                cfg_ready_d = 1'b0;
                if (cnt_q == CNT_LAST) begin
                    // Ready rises together with locked so a requester sees
                    // both on the same cycle.
                    locked_d    = 1'b1;
                    cnt_d       = {CNT_W{1'b0}};
                    state_d     = ST_IDLE;
                    cfg_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            ST_IDLE: begin
                cfg_ready_d = 1'b1;
                if (handshake_s) begin
                    if (ch_in_range(cfg_ch)) begin
                        req_ch_d    = cfg_ch;
                        req_inc_d   = cfg_inc;
                        req_phase_d = cfg_phase;
                        state_d     = ST_APPLY;
                        cfg_ready_d = 1'b0;
                    end else begin
                        // Bad index: flag it and leave everything else alone.
                        cfg_err_d = 1'b1;
                    end
                end else begin
                    cfg_err_d = 1'b0;
                end
            end

            ST_APPLY: begin
                locked_d    = 1'b0;
                cnt_d       = {CNT_W{1'b0}};
                state_d     = ST_SETTLE;
                cfg_ready_d = 1'b0;
            end

            default: begin
                // Unreachable encoding: fall back to a fresh settle.
                state_d     = ST_SETTLE;
                cnt_d       = {CNT_W{1'b0}};
                locked_d    = 1'b0;
                cfg_ready_d = 1'b0;
            end
        endcase
    end

    // Per-channel accumulator advance, or load of the latched request in APPLY.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sum_s[i]     = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
            acc_d[i]     = sum_s[i][ACC_W-1:0];
            inc_d[i]     = inc_q[i];
            outtick_d[i] = sum_s[i][ACC_W];
            outclk_d[i]  = sum_s[i][ACC_W-1];
            if (apply_s && (req_ch_q == CH_W'(i))) begin
                // A load is not a wrap, so the tick is suppressed this cycle.
                acc_d[i]     = req_phase_q;
                inc_d[i]     = req_inc_q;
                outtick_d[i] = 1'b0;
                outclk_d[i]  = req_phase_q[ACC_W-1];
            end else begin
                acc_d[i] = sum_s[i][ACC_W-1:0];
            end
        end
    end

    // FSM, settle counter, handshake outputs and request latch registers.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SETTLE;
            cnt_q       <= {CNT_W{1'b0}};
            locked_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            req_ch_q    <= {CH_W{1'b0}};
            req_inc_q   <= {ACC_W{1'b0}};
            req_phase_q <= {ACC_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            locked_q    <= locked_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            req_ch_q    <= req_ch_d;
            req_inc_q   <= req_inc_d;
            req_phase_q <= req_phase_d;
        end
    end

    // Accumulator, increment and clock/tick output registers for all channels.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= {ACC_W{1'b0}};
                inc_q[i] <= DEF_INC[i*ACC_W +: ACC_W];
            end
            outclk_q  <= {NUM_CH{1'b0}};
            outtick_q <= {NUM_CH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
                inc_q[i] <= inc_d[i];
            end
            outclk_q  <= outclk_d;
            outtick_q <= outtick_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
    assign outclk    = outclk_q;
    assign outtick   = outtick_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_nco_clock_gen.sv
// -----------------------------------------------------------------------------
// tb_nco_clock_gen
//
// Self-checking bench for nco_clock_gen (NUM_CH=3, ACC_W=32, LOCK_CYCLES=16,
// ch1 default increment 32'h4CCCCCCD). A cycle-level reference model tracks
// each channel's phase arithmetically and the lock timeline as a countdown of
// remaining settle edges; every cycle all outputs are compared to it. Directed
// scenarios are followed by a randomized request phase.
// -----------------------------------------------------------------------------
module tb_nco_clock_gen;

    localparam int          NUM_CH = 3;
    localparam int          LOCK   = 16;
    localparam logic [31:0] DEF1   = 32'h4CCCCCCD;

    logic               refclk = 1'b0;
    logic               rst    = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [2:0]         cfg_ch    = 3'd0;
    logic [31:0]        cfg_inc   = 32'h0;
    logic [31:0]        cfg_phase = 32'h0;
    logic               cfg_err;
    logic [2:0]         outclk;
    logic [2:0]         outtick;
    logic               locked;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_acc [NUM_CH];
    logic [31:0] m_inc [NUM_CH];
    logic [2:0]  m_clk, m_tick;
    logic        m_locked, m_ready, m_err;
    logic        m_pend, m_accept;
    logic [2:0]  m_pch;
    logic [31:0] m_pinc, m_pph;
    int          m_left;

    nco_clock_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (32),
        .LOCK_CYCLES (LOCK),
        .DEF_INC     ({32'h0, DEF1, 32'h0}),
        .CH_W        (3)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_phase (cfg_phase),
        .cfg_err   (cfg_err),
        .outclk    (outclk),
        .outtick   (outtick),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) m_acc[i] = 32'h0;
        m_inc[0] = 32'h0;
        m_inc[1] = DEF1;
        m_inc[2] = 32'h0;
        m_clk    = 3'b000;
        m_tick   = 3'b000;
        m_locked = 1'b0;
        m_ready  = 1'b0;
        m_err    = 1'b0;
        m_pend   = 1'b0;
        m_accept = 1'b0;
        m_left   = LOCK;
    endtask

    // Advance the model by one rising edge using the inputs seen at that edge.
    task automatic model_edge();
        logic [63:0] s;
        m_accept = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_pend && (32'(m_pch) == i)) begin
                    m_acc[i]  = m_pph;
                    m_inc[i]  = m_pinc;
                    m_tick[i] = 1'b0;
                    m_clk[i]  = m_pph[31];
                end else begin
                    s         = 64'(m_acc[i]) + 64'(m_inc[i]);
                    m_tick[i] = (s >= 64'h1_0000_0000);
                    m_acc[i]  = 32'(s % 64'h1_0000_0000);
                    m_clk[i]  = (m_acc[i] >= 32'h8000_0000);
                end
            end
            m_err = 1'b0;
            if (m_pend) begin
                m_pend   = 1'b0;
                m_locked = 1'b0;
                m_ready  = 1'b0;
                m_left   = LOCK;
            end else if (!m_locked) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_locked = 1'b1;
                    m_ready  = 1'b1;
                end
            end else if (cfg_valid) begin
                m_accept = 1'b1;
                if (32'(cfg_ch) < NUM_CH) begin
                    m_pend  = 1'b1;
                    m_pch   = cfg_ch;
                    m_pinc  = cfg_inc;
                    m_pph   = cfg_phase;
                    m_ready = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("outclk",    64'(outclk),    64'(m_clk));
        check_eq("outtick",   64'(outtick),   64'(m_tick));
        check_eq("locked",    64'(locked),    64'(m_locked));
        check_eq("cfg_ready", 64'(cfg_ready), 64'(m_ready));
        check_eq("cfg_err",   64'(cfg_err),   64'(m_err));
    endtask

    // One clock: edge, model update, then sample 1 time unit later.
    task automatic cycle();
        @(posedge refclk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic send_req(input logic [2:0] ch, input logic [31:0] inc, input logic [31:0] ph);
        int n;
        n         = 0;
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_inc   = inc;
        cfg_phase = ph;
        m_accept  = 1'b0;
        while (!m_accept && n < 200) begin
            cycle();
            n++;
        end
        cfg_valid = 1'b0;
        check_eq("req_wait", 64'(n < 200), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_outclk",  64'(outclk),    64'd0);
        check_eq("rst_outtick", 64'(outtick),   64'd0);
        check_eq("rst_locked",  64'(locked),    64'd0);
        check_eq("rst_ready",   64'(cfg_ready), 64'd0);
        check_eq("rst_err",     64'(cfg_err),   64'd0);
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic lock_sequence(input string tag);
        for (int k = 1; k <= LOCK; k++) begin
            cycle();
            if (k == LOCK - 1) check_eq({tag, "_edge15"}, 64'(locked), 64'd0);
            if (k == LOCK) begin
                check_eq({tag, "_edge16"},  64'(locked),    64'd1);
                check_eq({tag, "_ready16"}, 64'(cfg_ready), 64'd1);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t1, t0, quiet, consec;
        logic prev;

        // Post-reset lock
        #1;
        do_reset();
        lock_sequence("lock");

        // Default rate on ch1, ch0/ch2 idle
        t1 = 0; quiet = 0; consec = 0; prev = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            cycle();
            if (outtick[1]) t1++;
            if (outtick[1] && prev) consec++;
            prev = outtick[1];
            if (outtick[0] | outtick[2] | outclk[0] | outclk[2]) quiet++;
        end
        check_eq("ch1_rate",   64'((t1 >= 299) && (t1 <= 301)), 64'd1);
        check_eq("ch1_consec", 64'(consec), 64'd0);
        check_eq("ch02_quiet", 64'(quiet),  64'd0);

        // Reconfigure ch0 to a quarter of refclk
        send_req(3'd0, 32'h4000_0000, 32'h0);
        cycle();
        check_eq("cfg0_lock_drop", 64'(locked), 64'd0);
        t0 = 0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (outtick[0]) t0++;
        end
        check_eq("ch0_ticks40", 64'(t0), 64'd10);

        // Phase load on ch2
        send_req(3'd2, 32'h8000_0000, 32'h8000_0000);
        cycle();
        check_eq("ph_load_clk",  64'(outclk[2]),  64'd1);
        check_eq("ph_load_tick", 64'(outtick[2]), 64'd0);
        for (int k = 0; k < 20; k++) cycle();

        // Invalid channel index
        send_req(3'd3, 32'($urandom), 32'($urandom));
        check_eq("bad_ch_err",    64'(cfg_err),   64'd1);
        check_eq("bad_ch_locked", 64'(locked),    64'd1);
        check_eq("bad_ch_ready",  64'(cfg_ready), 64'd1);
        cycle();
        check_eq("bad_ch_err_end", 64'(cfg_err), 64'd0);
        for (int k = 0; k < 10; k++) cycle();

        // Reset five cycles into SETTLE after a reconfig
        send_req(3'd1, 32'h1234_5678, 32'hFFFF_0000);
        cycle();
        for (int k = 0; k < 5; k++) cycle();
        do_reset();
        lock_sequence("relock");
        for (int k = 0; k < 50; k++) cycle();

        // Randomized requests held until accepted
        for (int k = 0; k < 3000; k++) begin
            if (!cfg_valid) begin
                if ($urandom_range(0, 7) == 0) begin
                    cfg_valid = 1'b1;
                    cfg_ch    = 3'($urandom_range(0, 4));
                    case ($urandom_range(0, 3))
                        0:       cfg_inc = 32'h0;
                        1:       cfg_inc = 32'($urandom_range(1, 1 << 24));
                        2:       cfg_inc = 32'h8000_0000 | 32'($urandom);
                        default: cfg_inc = 32'($urandom);
                    endcase
                    cfg_phase = 32'($urandom);
                end else begin
                    cfg_ch    = 3'($urandom_range(0, 7));
                    cfg_inc   = 32'($urandom);
                    cfg_phase = 32'($urandom);
                end
            end
            cycle();
            if (m_accept) cfg_valid = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
